// File: rtl/input_sequencer.sv
// ----------------------------------------------------------------------------
// input_sequencer
//   Transmit side of the keypad-to-controller command handshake. Key commands
//   from the keypad decoder go into a small circular FIFO. One command at a
//   time is presented on in_cmd and held until the controller accepts it with
//   in_ack. After each acceptance in_cmd returns to IC_NON for a gap, so two
//   identical codes in a row are never seen as one command.
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   synchronous, active-low reset
//   key_valid  in   one-cycle strobe, key_code holds a new command
//   key_code   in   command code; IC_NON strobes are ignored
//   in_ack     in   controller ready (level)
//   in_cmd     out  command presented to the controller (registered)
//   busy       out  FIFO non-empty or handshake in progress (registered)
//   overflow   out  sticky, a key was dropped on a full FIFO
//   count      out  queued commands, excluding the one on in_cmd
// ----------------------------------------------------------------------------
module input_sequencer #(
   parameter int              IC_N     = 5,
   parameter logic [IC_N-1:0] IC_NON   = '0,
   parameter int              DEPTH_LG = 2,
   parameter int              GAP      = 1
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic                key_valid,
   input  logic [IC_N-1:0]     key_code,
   input  logic                in_ack,
   output logic [IC_N-1:0]     in_cmd,
   output logic                busy,
   output logic                overflow,
   output logic [DEPTH_LG:0]   count
);

   // state     | meaning
   // S_IDLE    | in_cmd = IC_NON, pop FIFO head when one is queued
   // S_PRESENT | in_cmd holds a command until in_ack is seen at an edge
   // S_GAP     | in_cmd = IC_NON for GAP cycles after an acceptance

   localparam int DEPTH = 2 ** DEPTH_LG;
   localparam int GW    = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [1:0] {S_IDLE, S_PRESENT, S_GAP} state_t;

   state_t              r_state;
   logic [IC_N-1:0]     r_mem [DEPTH];
   logic [DEPTH_LG-1:0] r_wr_ptr;
   logic [DEPTH_LG-1:0] r_rd_ptr;
   logic [DEPTH_LG:0]   r_count;
   logic [GW-1:0]       r_gap_cnt;
   logic [IC_N-1:0]     r_in_cmd;
   logic                r_busy;
   logic                r_overflow;

   logic                w_push;
   logic                w_pop;
   logic                w_full;
   logic                w_wr_en;
   logic                w_drop;
   logic [DEPTH_LG:0]   w_count_nxt;
   logic                w_active_nxt;

   assign w_push  = key_valid && (key_code != IC_NON);
   // Pop only reads registered contents, so a key written this edge is never
   // popped at the same edge.
   assign w_pop   = (r_state == S_IDLE) && (r_count != '0);
   assign w_full  = (r_count == (DEPTH_LG+1)'(DEPTH));
   assign w_wr_en = w_push && (!w_full || w_pop);
   assign w_drop  = w_push && w_full && !w_pop;

   always_comb begin
      w_count_nxt = r_count;
      if (w_wr_en && !w_pop)
         w_count_nxt = r_count + 1'b1;
      else if (w_pop && !w_wr_en)
         w_count_nxt = r_count - 1'b1;
   end

   // Whether the FSM will be outside IDLE after this edge; feeds registered busy.
   always_comb begin
      w_active_nxt = 1'b0;
      case (r_state)
         S_IDLE:    w_active_nxt = w_pop;
         S_PRESENT: w_active_nxt = 1'b1;
         S_GAP:     w_active_nxt = (r_gap_cnt != '0);
         default:   w_active_nxt = 1'b0;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (w_wr_en)
         r_mem[r_wr_ptr] <= key_code;
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         if (w_drop)
            r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         r_state   <= S_IDLE;
         r_in_cmd  <= IC_NON;
         r_gap_cnt <= '0;
         r_busy    <= 1'b0;
      end else begin
         r_busy <= w_active_nxt || (w_count_nxt != '0);
         case (r_state)
            S_IDLE: begin
               r_in_cmd <= IC_NON;
               if (w_pop) begin
                  r_in_cmd <= r_mem[r_rd_ptr];
                  r_state  <= S_PRESENT;
               end
            end
            S_PRESENT: begin
               if (in_ack) begin
                  r_in_cmd  <= IC_NON;
                  r_gap_cnt <= GW'(GAP - 1);
                  r_state   <= S_GAP;
               end
            end
            S_GAP: begin
               r_in_cmd <= IC_NON;
               if (r_gap_cnt == '0)
                  r_state <= S_IDLE;
               else
                  r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            default: begin
               r_in_cmd <= IC_NON;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign in_cmd   = r_in_cmd;
   assign busy     = r_busy;
   assign overflow = r_overflow;
   assign count    = r_count;

endmodule

// File: tb/tb_input_sequencer.sv
module tb_input_sequencer;

   logic       Clock;
   logic       Reset;
   logic       key_valid;
   logic [4:0] key_code;
   logic       in_ack;
   logic [4:0] in_cmd;
   logic       busy;
   logic       overflow;
   logic [2:0] count;

   int n_tests;
   int n_fail;
   int acc_cnt;

   input_sequencer #(
      .IC_N     (5),
      .IC_NON   (5'h00),
      .DEPTH_LG (2),
      .GAP      (1)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .key_valid (key_valid),
      .key_code  (key_code),
      .in_ack    (in_ack),
      .in_cmd    (in_cmd),
      .busy      (busy),
      .overflow  (overflow),
      .count     (count)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Independent acceptance counter: a non-NON command with in_ack high at an
   // edge outside reset.
   always @(posedge Clock) begin
      if (Reset === 1'b1 && in_cmd !== 5'h00 && in_ack === 1'b1)
         acc_cnt++;
   end

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic test_reset();
      Reset = 1'b0; key_valid = 1'b1; key_code = 5'h03; in_ack = 1'b0;
      repeat (3) tick();
      n_tests++;
      if (in_cmd !== 5'h00 || count !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_hold: in_cmd=%0h count=%0d ovf=%0b busy=%0b expected 0 0 0 0",
                  in_cmd, count, overflow, busy);
      end
      Reset = 1'b1; key_valid = 1'b0;
      tick();
      tick();
      n_tests++;
      if (in_cmd !== 5'h00 || count !== 3'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: in_cmd=%0h count=%0d busy=%0b expected 0 0 0",
                  in_cmd, count, busy);
      end
   endtask

   task automatic test_single();
      int a0;
      a0 = acc_cnt;
      in_ack = 1'b1;
      key_valid = 1'b1; key_code = 5'h03;
      tick();
      key_valid = 1'b0;
      n_tests++;
      if (count !== 3'd1 || in_cmd !== 5'h00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_queued: count=%0d in_cmd=%0h busy=%0b expected 1 0 1", count, in_cmd, busy);
      end
      tick();
      n_tests++;
      if (in_cmd !== 5'h03 || count !== 3'd0) begin
         n_fail++;
         $display("FAIL single_present: in_cmd=%0h count=%0d expected 3 0", in_cmd, count);
      end
      tick();
      n_tests++;
      if (in_cmd !== 5'h00 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_gap: in_cmd=%0h busy=%0b expected 0 1", in_cmd, busy);
      end
      tick();
      n_tests++;
      if (in_cmd !== 5'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL single_idle: in_cmd=%0h busy=%0b expected 0 0", in_cmd, busy);
      end
      n_tests++;
      if (acc_cnt - a0 != 1) begin
         n_fail++;
         $display("FAIL single_acc: got %0d acceptances expected 1", acc_cnt - a0);
      end
   endtask

   task automatic test_hold();
      int a0;
      int bad;
      a0 = acc_cnt;
      bad = 0;
      in_ack = 1'b0;
      key_valid = 1'b1; key_code = 5'h03;
      tick();
      key_valid = 1'b0;
      tick();
      for (int i = 0; i < 10; i++) begin
         if (in_cmd !== 5'h03) bad++;
         tick();
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL hold_stable: %0d cycles without 03, expected 0", bad);
      end
      in_ack = 1'b1;
      tick();
      n_tests++;
      if (in_cmd !== 5'h00) begin
         n_fail++;
         $display("FAIL hold_release: in_cmd=%0h expected 0", in_cmd);
      end
      repeat (3) tick();
      n_tests++;
      if (acc_cnt - a0 != 1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_acc: acceptances=%0d busy=%0b expected 1 0", acc_cnt - a0, busy);
      end
   endtask

   task automatic test_back_to_back();
      logic [4:0] exp_seq [5];
      int a0;
      a0 = acc_cnt;
      exp_seq[0] = 5'h07; exp_seq[1] = 5'h00; exp_seq[2] = 5'h00;
      exp_seq[3] = 5'h07; exp_seq[4] = 5'h00;
      in_ack = 1'b1;
      key_valid = 1'b1; key_code = 5'h07;
      tick();
      tick();
      key_valid = 1'b0;
      n_tests++;
      if (count !== 3'd1) begin
         n_fail++;
         $display("FAIL b2b_count: count=%0d expected 1", count);
      end
      for (int i = 0; i < 5; i++) begin
         n_tests++;
         if (in_cmd !== exp_seq[i]) begin
            n_fail++;
            $display("FAIL b2b_seq[%0d]: in_cmd=%0h expected %0h", i, in_cmd, exp_seq[i]);
         end
         tick();
      end
      n_tests++;
      if (acc_cnt - a0 != 2 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_acc: acceptances=%0d busy=%0b expected 2 0", acc_cnt - a0, busy);
      end
   endtask

   task automatic test_overflow();
      logic [4:0] got [$];
      int a0;
      int guard;
      a0 = acc_cnt;
      in_ack = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         key_valid = 1'b1; key_code = 5'(k);
         tick();
      end
      n_tests++;
      if (count !== 3'd4 || overflow !== 1'b0 || in_cmd !== 5'h01) begin
         n_fail++;
         $display("FAIL ovf_full: count=%0d ovf=%0b in_cmd=%0h expected 4 0 1", count, overflow, in_cmd);
      end
      key_code = 5'h06;
      tick();
      key_valid = 1'b0;
      n_tests++;
      if (count !== 3'd4 || overflow !== 1'b1 || in_cmd !== 5'h01) begin
         n_fail++;
         $display("FAIL ovf_drop: count=%0d ovf=%0b in_cmd=%0h expected 4 1 1", count, overflow, in_cmd);
      end
      in_ack = 1'b1;
      guard = 0;
      while (busy === 1'b1 && guard < 60) begin
         if (in_cmd !== 5'h00) got.push_back(in_cmd);
         tick();
         guard++;
      end
      n_tests++;
      if (guard >= 60) begin
         n_fail++;
         $display("FAIL ovf_drain_timeout: busy=%0b after %0d cycles expected 0", busy, guard);
      end
      n_tests++;
      if (got.size() != 5) begin
         n_fail++;
         $display("FAIL ovf_deliv_count: got %0d commands expected 5", got.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (got[i] !== 5'(i + 1)) begin
               n_fail++;
               $display("FAIL ovf_order[%0d]: got %0h expected %0h", i, got[i], i + 1);
            end
         end
      end
      n_tests++;
      if (overflow !== 1'b1 || acc_cnt - a0 != 5) begin
         n_fail++;
         $display("FAIL ovf_sticky: ovf=%0b acceptances=%0d expected 1 5", overflow, acc_cnt - a0);
      end
   endtask

   task automatic test_non_code();
      key_valid = 1'b1; key_code = 5'h00;
      tick();
      key_valid = 1'b0;
      tick();
      tick();
      n_tests++;
      if (count !== 3'd0 || in_cmd !== 5'h00 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL non_code: count=%0d in_cmd=%0h busy=%0b expected 0 0 0", count, in_cmd, busy);
      end
   endtask

   task automatic test_reset_mid();
      int a0;
      int bad;
      in_ack = 1'b0;
      key_valid = 1'b1; key_code = 5'h0A; tick();
      key_code = 5'h0B; tick();
      key_code = 5'h0C; tick();
      key_valid = 1'b0;
      n_tests++;
      if (count !== 3'd2 || in_cmd !== 5'h0A) begin
         n_fail++;
         $display("FAIL mid_setup: count=%0d in_cmd=%0h expected 2 a", count, in_cmd);
      end
      Reset = 1'b0;
      tick();
      n_tests++;
      if (in_cmd !== 5'h00 || count !== 3'd0 || overflow !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: in_cmd=%0h count=%0d ovf=%0b busy=%0b expected 0 0 0 0",
                  in_cmd, count, overflow, busy);
      end
      Reset = 1'b1;
      in_ack = 1'b1;
      a0 = acc_cnt;
      bad = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (in_cmd !== 5'h00) bad++;
      end
      n_tests++;
      if (bad != 0 || acc_cnt != a0) begin
         n_fail++;
         $display("FAIL mid_no_deliver: nonzero cycles=%0d acceptances=%0d expected 0 0", bad, acc_cnt - a0);
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      acc_cnt = 0;
      Reset = 1'b0; key_valid = 1'b0; key_code = 5'h00; in_ack = 1'b0;
      test_reset();
      test_single();
      test_hold();
      test_back_to_back();
      test_overflow();
      test_non_code();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
